// File: rtl/bats_feed_arbiter.sv
// bats_feed_arbiter: A/B packet-level line arbiter in front of the PITCH parser.
// Chooses one of two redundant feeds per packet from its Sequenced Unit Header,
// then forwards the packet whole (gap-free, in order) or discards it whole.
module bats_feed_arbiter #(
    parameter logic [7:0]  UNIT  = 8'h01,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk40,
    input  logic             reset_n,
    input  logic [71:0]      a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [71:0]      b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [71:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             resync,
    output logic [31:0]      expected_seq,
    output logic             seq_locked,
    output logic             gap_pulse,
    output logic [CNT_W-1:0] gap_count,
    output logic [CNT_W-1:0] dup_count,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_FWD    = 2'd2,
        ST_DROP   = 2'd3
    } state_t;

    // Header seq is little-endian in bytes 4..7; byte 4 sits in bits 31:24.
    function automatic logic [31:0] le32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // True when x precedes y in modular (serial-number) order.
    function automatic logic seq_before(input logic [31:0] x, input logic [31:0] y);
        return 1'((x - y) >> 31);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic             r_sel;            // 0 = feed A, 1 = feed B
    logic [7:0]       r_cnt;
    logic [7:0]       r_unit;
    logic [7:0]       r_be;
    logic [31:0]      r_seq;
    logic [31:0]      r_exp;
    logic             r_locked;
    logic             r_gap_pulse;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] r_dup_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [31:0]      w_a_seq;
    logic [31:0]      w_b_seq;
    logic             w_a_elig;
    logic             w_b_elig;
    logic             w_pick_b;
    logic [31:0]      w_d;
    logic             w_bad;
    logic             w_hb;
    logic             w_dup;
    logic             w_to_drop;
    logic [71:0]      w_sel_data;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic             w_sel_ready;

    assign w_a_seq  = le32(a_data[31:0]);
    assign w_b_seq  = le32(b_data[31:0]);
    assign w_a_elig = a_valid && (a_data[39:32] == UNIT);
    assign w_b_elig = b_valid && (b_data[39:32] == UNIT);

    // Header classification of the latched packet (meaningful in DECIDE).
    assign w_d       = r_seq - r_exp;
    assign w_bad     = (r_be != 8'hFF) || (r_unit != UNIT);
    assign w_hb      = (r_cnt == 8'd0);
    assign w_dup     = r_locked && w_d[31];
    assign w_to_drop = w_bad || w_hb || w_dup;

    // Feed choice in IDLE: lower seq wins among eligible headers, A on ties.
    always_comb begin
        w_pick_b = 1'b0;
        if (a_valid && b_valid) begin
            if (w_a_elig && w_b_elig) begin
                w_pick_b = seq_before(w_b_seq, w_a_seq);
            end else if (w_b_elig && !w_a_elig) begin
                w_pick_b = 1'b1;
            end else begin
                w_pick_b = 1'b0;
            end
        end else if (b_valid) begin
            w_pick_b = 1'b1;
        end else begin
            w_pick_b = 1'b0;
        end
    end

    // Selected-feed mux used by FWD/DROP.
    always_comb begin
        if (r_sel) begin
            w_sel_data  = b_data;
            w_sel_valid = b_valid;
            w_sel_last  = b_last;
        end else begin
            w_sel_data  = a_data;
            w_sel_valid = a_valid;
            w_sel_last  = a_last;
        end
    end

    // Next-state logic and pass-through/ready outputs.
    always_comb begin
        w_next      = r_state;
        w_sel_ready = 1'b0;
        out_data    = 72'd0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (a_valid || b_valid) begin
                    w_next = ST_DECIDE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_DECIDE: begin
                if (w_to_drop) begin
                    w_next = ST_DROP;
                end else begin
                    w_next = ST_FWD;
                end
            end
            ST_FWD: begin
                out_data    = w_sel_data;
                out_valid   = w_sel_valid;
                w_sel_ready = out_ready;
                if (w_sel_valid && out_ready && w_sel_last) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_FWD;
                end
            end
            ST_DROP: begin
                w_sel_ready = 1'b1;
                if (w_sel_valid && w_sel_last) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_DROP;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        a_ready = w_sel_ready && !r_sel;
        b_ready = w_sel_ready && r_sel;
    end

    // State register.
    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the chosen feed and its header fields when leaving IDLE.
    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            r_sel  <= 1'b0;
            r_cnt  <= 8'd0;
            r_unit <= 8'd0;
            r_be   <= 8'd0;
            r_seq  <= 32'd0;
        end else if ((r_state == ST_IDLE) && (a_valid || b_valid)) begin
            r_sel <= w_pick_b;
            if (w_pick_b) begin
                r_cnt  <= b_data[47:40];
                r_unit <= b_data[39:32];
                r_be   <= b_data[71:64];
                r_seq  <= w_b_seq;
            end else begin
                r_cnt  <= a_data[47:40];
                r_unit <= a_data[39:32];
                r_be   <= a_data[71:64];
                r_seq  <= w_a_seq;
            end
        end
    end

    // Sequence tracking, gap pulse and statistics, all applied on leaving DECIDE.
    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            r_exp       <= 32'd0;
            r_locked    <= 1'b0;
            r_gap_pulse <= 1'b0;
            r_gap_cnt   <= {CNT_W{1'b0}};
            r_dup_cnt   <= {CNT_W{1'b0}};
            r_drop_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_gap_pulse <= 1'b0;
            if (r_state == ST_DECIDE) begin
                if (w_bad) begin
                    r_drop_cnt <= sat_inc(r_drop_cnt);
                end else if (w_hb) begin
                    r_exp <= r_exp;     // heartbeats leave tracking untouched
                end else if (!r_locked) begin
                    r_exp    <= r_seq + {24'd0, r_cnt};
                    r_locked <= 1'b1;
                end else if (w_d == 32'd0) begin
                    r_exp <= r_exp + {24'd0, r_cnt};
                end else if (w_dup) begin
                    r_dup_cnt <= sat_inc(r_dup_cnt);
                end else begin
                    r_exp       <= r_seq + {24'd0, r_cnt};
                    r_gap_pulse <= 1'b1;
                    r_gap_cnt   <= sat_inc(r_gap_cnt);
                end
            end
            // resync wins over any lock taken on the same edge
            if (resync) begin
                r_locked <= 1'b0;
            end
        end
    end

    assign expected_seq = r_exp;
    assign seq_locked   = r_locked;
    assign gap_pulse    = r_gap_pulse;
    assign gap_count    = r_gap_cnt;
    assign dup_count    = r_dup_cnt;
    assign drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_bats_feed_arbiter.sv
// Self-checking bench for bats_feed_arbiter: directed scenarios plus random
// packet streams, scored against a packet-level reference model.
module tb_bats_feed_arbiter;
    localparam logic [7:0] UNIT  = 8'h01;
    localparam int         CNT_W = 16;

    logic              Clk40     = 1'b0;
    logic              reset_n   = 1'b0;
    logic [71:0]       a_data    = 72'd0;
    logic              a_valid   = 1'b0;
    logic              a_last    = 1'b0;
    logic              a_ready;
    logic [71:0]       b_data    = 72'd0;
    logic              b_valid   = 1'b0;
    logic              b_last    = 1'b0;
    logic              b_ready;
    logic [71:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              resync    = 1'b0;
    logic [31:0]       expected_seq;
    logic              seq_locked;
    logic              gap_pulse;
    logic [CNT_W-1:0]  gap_count;
    logic [CNT_W-1:0]  dup_count;
    logic [CNT_W-1:0]  drop_count;

    always #5 Clk40 = ~Clk40;

    bats_feed_arbiter #(.UNIT(UNIT), .CNT_W(CNT_W)) dut (
        .Clk40(Clk40), .reset_n(reset_n),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .resync(resync), .expected_seq(expected_seq), .seq_locked(seq_locked),
        .gap_pulse(gap_pulse), .gap_count(gap_count), .dup_count(dup_count),
        .drop_count(drop_count)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [71:0] aq_d[$];
    logic [71:0] bq_d[$];
    logic [71:0] exp_q[$];
    bit          aq_l[$];
    bit          bq_l[$];
    bit          bubbles = 1'b0;
    bit          rdy_always = 1'b0;
    bit          hold_pend = 1'b0;
    logic [71:0] held = 72'd0;
    int          gap_seen = 0;
    // reference model state
    bit          m_locked = 1'b0;
    logic [31:0] m_exp = 32'd0;
    int          m_gap = 0;
    int          m_dup = 0;
    int          m_drop = 0;

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Build a packet, queue it on A (and an identical copy on B), and apply the model.
    task automatic add_pkt(input bit dual, input logic [31:0] seq, input logic [7:0] cnt,
                           input logic [7:0] unit, input logic [7:0] be, input int nbeats);
        logic [7:0]  by[8];
        logic [71:0] w;
        logic [71:0] beats[$];
        bit          fwd;
        by[0] = 8'(nbeats * 8);
        by[1] = 8'h00;
        by[2] = cnt;
        by[3] = unit;
        for (int k = 0; k < 4; k++) by[4+k] = seq[8*k +: 8];
        w[71:64] = be;
        for (int k = 0; k < 8; k++) w[63-8*k -: 8] = by[k];
        beats.push_back(w);
        for (int k = 1; k < nbeats; k++)
            beats.push_back({8'($urandom), 32'($urandom), 32'($urandom)});
        for (int k = 0; k < nbeats; k++) begin
            aq_d.push_back(beats[k]);
            aq_l.push_back(k == nbeats - 1);
            if (dual) begin
                bq_d.push_back(beats[k]);
                bq_l.push_back(k == nbeats - 1);
            end
        end
        fwd = 1'b0;
        if (be != 8'hFF || unit != UNIT) begin
            m_drop += dual ? 2 : 1;
        end else if (cnt != 8'd0) begin
            if (!m_locked) begin
                fwd = 1'b1; m_locked = 1'b1; m_exp = seq + 32'(cnt);
            end else if (seq == m_exp) begin
                fwd = 1'b1; m_exp = m_exp + 32'(cnt);
            end else if ((seq - m_exp) >= 32'h8000_0000) begin
                m_dup++;
            end else begin
                fwd = 1'b1; m_gap++; m_exp = seq + 32'(cnt);
            end
            // the redundant copy always trails an already-processed twin
            if (dual) m_dup++;
        end
        if (fwd) foreach (beats[k]) exp_q.push_back(beats[k]);
    endtask

    // One clock: score outputs at negedge, then advance feeds after posedge.
    task automatic cycle();
        bit a_fire, b_fire;
        @(negedge Clk40);
        if (hold_pend) begin
            chk("hold_valid", 72'(out_valid), 72'd1);
            chk("hold_data", out_data, held);
        end
        hold_pend = out_valid && !out_ready;
        held = out_data;
        if (out_valid && out_ready) begin
            chk("out_beat_expected", 72'(exp_q.size() > 0), 72'd1);
            if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
        end
        if (gap_pulse) gap_seen++;
        if (bq_d.size() == 0) chk("b_ready_unused", 72'(b_ready), 72'd0);
        a_fire = a_valid && a_ready;
        b_fire = b_valid && b_ready;
        @(posedge Clk40);
        #1;
        if (a_fire) begin
            void'(aq_d.pop_front()); void'(aq_l.pop_front()); a_valid = 1'b0;
        end
        if (!a_valid && aq_d.size() > 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
            a_valid = 1'b1; a_data = aq_d[0]; a_last = aq_l[0];
        end
        if (b_fire) begin
            void'(bq_d.pop_front()); void'(bq_l.pop_front()); b_valid = 1'b0;
        end
        if (!b_valid && bq_d.size() > 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
            b_valid = 1'b1; b_data = bq_d[0]; b_last = bq_l[0];
        end
        out_ready = rdy_always ? 1'b1 : ($urandom_range(0, 9) < 7);
    endtask

    // Run until every queued beat is consumed and delivered, then check state.
    task automatic drain(input string tag);
        int t = 0;
        while ((aq_d.size() != 0 || bq_d.size() != 0 || exp_q.size() != 0) && t < 5000) begin
            cycle();
            t++;
        end
        chk({tag, "_done_in_time"}, 72'(t < 5000), 72'd1);
        repeat (3) cycle();
        chk({tag, "_expected_seq"}, 72'(expected_seq), 72'(m_exp));
        chk({tag, "_seq_locked"}, 72'(seq_locked), 72'(m_locked));
        chk({tag, "_gap_count"}, 72'(gap_count), 72'(m_gap));
        chk({tag, "_dup_count"}, 72'(dup_count), 72'(m_dup));
        chk({tag, "_drop_count"}, 72'(drop_count), 72'(m_drop));
        chk({tag, "_gap_pulses"}, 72'(gap_seen), 72'(m_gap));
    endtask

    task automatic do_resync();
        resync = 1'b1;
        cycle();
        resync = 1'b0;
        m_locked = 1'b0;
        cycle();
        chk("resync_unlocked", 72'(seq_locked), 72'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_a_ready"}, 72'(a_ready), 72'd0);
        chk({tag, "_b_ready"}, 72'(b_ready), 72'd0);
        chk({tag, "_out_valid"}, 72'(out_valid), 72'd0);
        chk({tag, "_out_data"}, out_data, 72'd0);
        chk({tag, "_gap_pulse"}, 72'(gap_pulse), 72'd0);
        chk({tag, "_seq_locked"}, 72'(seq_locked), 72'd0);
        chk({tag, "_expected_seq"}, 72'(expected_seq), 72'd0);
        chk({tag, "_counters"}, 72'({gap_count, dup_count, drop_count}), 72'd0);
    endtask

    task automatic random_stream(input bit dual, input int npkt);
        logic [31:0] g, seq;
        logic [7:0]  cnt, unit, be;
        int          kind;
        g = m_exp;
        for (int p = 0; p < npkt; p++) begin
            kind = $urandom_range(0, 9);
            cnt  = 8'($urandom_range(1, 5));
            unit = UNIT;
            be   = 8'hFF;
            seq  = $urandom;
            if (kind <= 4) begin
                seq = g; g = g + 32'(cnt);
            end else if (kind == 5) begin
                seq = g + 32'($urandom_range(1, 20)); g = seq + 32'(cnt);
            end else if (kind == 6) begin
                seq = g - 32'($urandom_range(1, 10));
            end else if (kind == 7) begin
                unit = UNIT ^ 8'($urandom_range(1, 255));
            end else if (kind == 8) begin
                be = 8'($urandom_range(0, 254));
            end else begin
                cnt = 8'd0;
            end
            add_pkt(dual, seq, cnt, unit, be, $urandom_range(1, 4));
        end
    endtask

    initial begin
        int t;
        repeat (2) @(posedge Clk40);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        cycle();
        check_reset_values("post_reset");

        // in-order single feed
        add_pkt(1'b0, 32'd1, 8'd2, UNIT, 8'hFF, 3);
        add_pkt(1'b0, 32'd3, 8'd1, UNIT, 8'hFF, 3);
        drain("in_order");

        // redundant feeds presenting the same packet together
        do_resync();
        add_pkt(1'b1, 32'd10, 8'd1, UNIT, 8'hFF, 2);
        drain("redundant");

        // wrap followed by a gap
        do_resync();
        add_pkt(1'b0, 32'hFFFF_FFFE, 8'd1, UNIT, 8'hFF, 2);
        add_pkt(1'b0, 32'hFFFF_FFFF, 8'd2, UNIT, 8'hFF, 1);
        add_pkt(1'b0, 32'd5, 8'd1, UNIT, 8'hFF, 4);
        drain("wrap_gap");

        // filtering: foreign unit, partial enables, heartbeat
        add_pkt(1'b0, m_exp, 8'd1, 8'h02, 8'hFF, 2);
        add_pkt(1'b0, m_exp, 8'd1, UNIT, 8'hF0, 3);
        add_pkt(1'b0, m_exp, 8'd0, UNIT, 8'hFF, 1);
        drain("filter");

        // resync then re-lock on an unrelated seq without a gap
        do_resync();
        add_pkt(1'b0, 32'd100, 8'd3, UNIT, 8'hFF, 4);
        drain("relock");

        // random traffic, single feed then redundant feeds
        bubbles = 1'b1;
        random_stream(1'b0, 40);
        drain("rand_single");
        random_stream(1'b1, 40);
        drain("rand_dual");

        // reset in the middle of a forwarded packet
        bubbles = 1'b0;
        rdy_always = 1'b1;
        add_pkt(1'b0, m_exp, 8'd1, UNIT, 8'hFF, 4);
        t = 0;
        while (!out_valid && t < 50) begin
            cycle();
            t++;
        end
        chk("mid_fwd_reached", 72'(out_valid), 72'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_fwd_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bats_feed_arbiter.md
# bats_feed_arbiter

Packet-level A/B line arbiter in front of the BATS PITCH parser. Takes two redundant UDP payload streams, each carrying Sequenced Unit Header packets. Forwards exactly one gap-free, de-duplicated packet stream into the parser's 72-bit UDP input. Decisions use the header's sequence number and count; each packet is forwarded or discarded whole.

## Interface
- UNIT, default 8'h01: only packets whose Hdr Unit equals this value are eligible; others are dropped.
- CNT_W, default 16: width of the saturating statistics counters.
- Clk40  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- a_data / b_data  in  72  bits 63:0 are payload, with byte 0 in bits 63:56. Bits 71:64 are byte enables; bit 71 is byte 0.
- a_valid / b_valid  in  1  beat valid.
- a_last / b_last  in  1  last beat of a UDP packet.
- a_ready / b_ready  out  1  beat consumed when valid && ready.
- out_data  out  72  to parser data input.
- out_valid  out  1  to parser data_valid input.
- out_ready  in  1  parser Ready_for_Udp_Input.
- resync  in  1  single-cycle pulse; clears sequence lock.
- expected_seq  out  32  next sequence number expected.
- seq_locked  out  1  expected_seq is valid.
- gap_pulse  out  1  one-cycle pulse when a gap is detected.
- gap_count, dup_count, drop_count  out  CNT_W  saturating counters.

## Operation
- The header is the first beat of a packet. In little-endian byte order: bytes 0-1 are length, byte 2 is count, byte 3 is unit, bytes 4-7 are seq.
- States are IDLE, DECIDE, FWD, DROP.
- **IDLE:** a_ready and b_ready are 0.
  - If any input has valid, latch its header fields and go to DECIDE.
  - If both inputs are valid and both headers are eligible, pick the one with the lower seq by modular compare. On a tie, pick A; B's copy then drops later as a duplicate.
  - If only one header is eligible, pick that one. Otherwise pick A.
- **DECIDE:** classify the selected header. The header word itself is not yet consumed.
  - Malformed (byte enables != 8'hFF), or unit != UNIT: go to DROP and increment drop_count.
  - count == 0 (heartbeat/unsequenced): go to DROP. drop_count is unchanged and expected_seq is unchanged.
  - Not locked: go to FWD. Set expected_seq = seq + count and seq_locked = 1.
  - Locked: compute d = seq - expected_seq, mod 2^32.
    - d == 0: in order. Go to FWD; expected_seq += count.
    - d[31] == 1: duplicate or stale. Go to DROP; increment dup_count.
    - Otherwise: gap. Go to FWD; expected_seq = seq + count, pulse gap_pulse, increment gap_count.
- **FWD:**
  - The selected input passes through combinationally: out_data = sel_data, out_valid = sel_valid, sel_ready = out_ready.
  - The unselected input's ready is 0.
  - Leave to IDLE on a handshake with sel_last = 1.
- **DROP:** sel_ready = 1 and out_valid = 0. Leave to IDLE on a consumed beat with sel_last = 1.
- All arithmetic is 32-bit wrapping; expected_seq wraps from 32'hFFFFFFFF to 0.
- Counters saturate at all-ones.
- resync clears seq_locked at the next edge. If resync arrives during FWD or DROP, the current packet completes and the next packet re-locks. expected_seq is unchanged until that re-lock.
- If a packet's header is the last beat (single-beat packet), FWD/DROP completes on that beat.

## Timing
- Reset values: state IDLE; a_ready, b_ready, out_valid, gap_pulse, seq_locked = 0; expected_seq = 0; all counters = 0; out_data = 0.
- Decision overhead is 2 cycles per packet (IDLE latch, DECIDE). After that, FWD is zero-latency pass-through at one beat per cycle while out_ready = 1.
- Minimum packet-to-packet gap on out_valid is 2 cycles.
- out_valid and out_data stay stable while out_valid && !out_ready. This follows from the pass-through and the upstream holding its beat.
- gap_pulse and all counter/expected_seq updates take effect at the DECIDE→FWD/DROP edge.
- reset_n mid-packet aborts immediately to reset values. Upstream buffers share reset_n, so no partial packet survives. No mid-packet recovery is required.

## Test plan
- **In-order single feed:** A sends seq 1 cnt 2, then seq 3 cnt 1, 3 beats each; B idle → both packets appear on out unchanged; expected_seq = 4; all counters 0.
- **Redundant feeds:** A and B both present seq 10 cnt 1 in the same cycle → A's copy is forwarded; B's copy is dropped; dup_count = 1; expected_seq = 11.
- **Gap and wrap:**
  - Lock at seq 32'hFFFFFFFE cnt 1.
  - Next packet seq 32'hFFFFFFFF cnt 2 → forwarded in order; expected_seq = 1.
  - Next packet seq 5 → forwarded; gap_pulse for one cycle; gap_count = 1; expected_seq = 5 + cnt.
- **Backpressure:** out_ready toggled 1,0,0,1 during a 4-beat FWD → every beat delivered exactly once; out_data is held while stalled; B_ready stays 0 throughout.
- **Filtering:** headers with unit 8'h02, byte enables 8'hF0, and count 0 → none forwarded. drop_count = 2 (unit and byte-enable cases); the heartbeat is not counted; expected_seq is unchanged.
- **Reset/resync:**
  - resync pulse, then seq 100 → forwarded with no gap_pulse; expected_seq = 100 + cnt.
  - reset_n low mid-FWD → all outputs at reset values the same cycle.
